// File: rtl/reset_sequencer.sv
// Staged reset controller: qualifies PLL lock, then releases the memory
// controller, the video subsystem and the CPU in that order. It also handles
// memory-init timeout retries, PLL loss and a CPU-only soft reset.
module reset_sequencer #(
  parameter int LOCK_FILTER = 16,
  parameter int STAGE_GAP   = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int SOFT_HOLD   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       mem_ready,
  input  logic       soft_req,
  output logic       mem_rst_n,
  output logic       video_rst_n,
  output logic       cpu_rst_n,
  output logic       sys_ready,
  output logic       mem_timeout,
  output logic [2:0] state
);

  localparam int MAX_AB = (LOCK_FILTER > STAGE_GAP) ? LOCK_FILTER : STAGE_GAP;
  localparam int MAX_CD = (MEM_TIMEOUT > SOFT_HOLD) ? MEM_TIMEOUT : SOFT_HOLD;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  // Terminal counts: the stage event fires on the edge where cnt holds N-1.
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_HOLD - 1);

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] WAIT_MEM  = 3'd1;
  localparam logic [2:0] GAP_VIDEO = 3'd2;
  localparam logic [2:0] GAP_CPU   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] SOFT      = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mem_rst_n_reg, mem_rst_n_next;
  logic          video_rst_n_reg, video_rst_n_next;
  logic          cpu_rst_n_reg, cpu_rst_n_next;
  logic          sys_ready_reg, sys_ready_next;
  logic          mem_timeout_reg, mem_timeout_next;

  // Next-state logic; PLL loss outranks every per-state event.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    mem_rst_n_next   = mem_rst_n_reg;
    video_rst_n_next = video_rst_n_reg;
    cpu_rst_n_next   = cpu_rst_n_reg;
    sys_ready_next   = sys_ready_reg;
    mem_timeout_next = mem_timeout_reg;

    if (state_reg != WAIT_LOCK && !pll_locked) begin
      // Lost lock: drop every stage but keep the sticky timeout flag.
      state_next       = WAIT_LOCK;
      cnt_next         = '0;
      mem_rst_n_next   = 1'b0;
      video_rst_n_next = 1'b0;
      cpu_rst_n_next   = 1'b0;
      sys_ready_next   = 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (!pll_locked) begin
            cnt_next = '0;
          end else if (cnt_reg == LOCK_LAST) begin
            mem_rst_n_next = 1'b1;
            state_next     = WAIT_MEM;
            cnt_next       = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WAIT_MEM: begin
          // mem_ready wins over a timeout landing on the same edge.
          if (mem_ready) begin
            state_next = GAP_VIDEO;
            cnt_next   = '0;
          end else if (cnt_reg == MEM_LAST) begin
            mem_timeout_next = 1'b1;
            mem_rst_n_next   = 1'b0;
            state_next       = WAIT_LOCK;
            cnt_next         = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        GAP_VIDEO: begin
          if (cnt_reg == GAP_LAST) begin
            video_rst_n_next = 1'b1;
            state_next       = GAP_CPU;
            cnt_next         = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        GAP_CPU: begin
          if (cnt_reg == GAP_LAST) begin
            cpu_rst_n_next = 1'b1;
            sys_ready_next = 1'b1;
            state_next     = RUN;
            cnt_next       = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (soft_req) begin
            cpu_rst_n_next = 1'b0;
            sys_ready_next = 1'b0;
            state_next     = SOFT;
            cnt_next       = '0;
          end
        end
        SOFT: begin
          // Counter saturates at terminal; a held request keeps the CPU down.
          if (cnt_reg == SOFT_LAST) begin
            if (!soft_req) begin
              cpu_rst_n_next = 1'b1;
              sys_ready_next = 1'b1;
              state_next     = RUN;
              cnt_next       = '0;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          // Unreachable encodings recover through a full restart.
          state_next       = WAIT_LOCK;
          cnt_next         = '0;
          mem_rst_n_next   = 1'b0;
          video_rst_n_next = 1'b0;
          cpu_rst_n_next   = 1'b0;
          sys_ready_next   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= WAIT_LOCK;
      cnt_reg         <= '0;
      mem_rst_n_reg   <= 1'b0;
      video_rst_n_reg <= 1'b0;
      cpu_rst_n_reg   <= 1'b0;
      sys_ready_reg   <= 1'b0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      mem_rst_n_reg   <= mem_rst_n_next;
      video_rst_n_reg <= video_rst_n_next;
      cpu_rst_n_reg   <= cpu_rst_n_next;
      sys_ready_reg   <= sys_ready_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  assign mem_rst_n   = mem_rst_n_reg;
  assign video_rst_n = video_rst_n_reg;
  assign cpu_rst_n   = cpu_rst_n_reg;
  assign sys_ready   = sys_ready_reg;
  assign mem_timeout = mem_timeout_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: scenarios push expected output snapshots keyed
// by absolute edge number; a monitor pops and compares them after each edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       mem_ready = 1'b0;
  logic       soft_req = 1'b0;
  logic       mem_rst_n, video_rst_n, cpu_rst_n, sys_ready, mem_timeout;
  logic [2:0] state;

  reset_sequencer dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .mem_ready(mem_ready),
    .soft_req(soft_req), .mem_rst_n(mem_rst_n), .video_rst_n(video_rst_n),
    .cpu_rst_n(cpu_rst_n), .sys_ready(sys_ready), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] snap;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   inv_en = 1'b0;

  // One comparison: count it, report on mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Snapshot order: {mem, video, cpu, sys_ready, mem_timeout, state[2:0]}.
  task automatic expect_at(input int e, input logic [7:0] snap, input string tag);
    exp_t x;
    x.cyc  = base + e;
    x.snap = snap;
    x.tag  = tag;
    sb_q.push_back(x);
  endtask

  // Return at the negedge after relative edge e; inputs set now hit edge e+1.
  task automatic wait_edge(input int e);
    while (cyc < base + e) @(negedge clk);
  endtask

  // Hold reset for n edges; edge 1 is the first edge sampling reset low.
  task automatic do_reset(input int n);
    exp_t x;
    @(negedge clk);
    reset = 1'b1;
    x.cyc = cyc + 1; x.snap = 8'b0; x.tag = "reset_state";
    sb_q.push_back(x);
    repeat (n) @(negedge clk);
    reset = 1'b0;
    base = cyc;
    inv_en = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop plus invariant monitor, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        if (sb_q[i].cyc < cyc)
          check({sb_q[i].tag, "_missed"}, 32'(sb_q[i].cyc), 32'(cyc));
        else begin
          $display("[sb] edge %0d (rel %0d) %s: got %b exp %b", cyc, cyc - base,
                   sb_q[i].tag,
                   {mem_rst_n, video_rst_n, cpu_rst_n, sys_ready, mem_timeout, state},
                   sb_q[i].snap);
          check(sb_q[i].tag,
                32'({mem_rst_n, video_rst_n, cpu_rst_n, sys_ready, mem_timeout, state}),
                32'(sb_q[i].snap));
        end
        sb_q.delete(i);
      end
    end
    if (inv_en) begin
      check("inv_order", 32'((!cpu_rst_n || video_rst_n) && (!video_rst_n || mem_rst_n)), 32'd1);
      check("inv_ready", 32'(sys_ready), 32'(state == 3'd4));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cold start, then PLL loss in RUN.
    pll_locked = 1'b1; mem_ready = 1'b0; soft_req = 1'b0;
    do_reset(4);
    expect_at(15, 8'b0_0_0_0_0_000, "cold_pre_mem");
    expect_at(16, 8'b1_0_0_0_0_001, "cold_mem_rel");
    expect_at(26, 8'b1_0_0_0_0_010, "cold_mem_ready");
    expect_at(33, 8'b1_0_0_0_0_010, "cold_pre_video");
    expect_at(34, 8'b1_1_0_0_0_011, "cold_video_rel");
    expect_at(41, 8'b1_1_0_0_0_011, "cold_pre_cpu");
    expect_at(42, 8'b1_1_1_1_0_100, "cold_cpu_rel");
    expect_at(45, 8'b0_0_0_0_0_000, "pll_loss_run");
    wait_edge(25); mem_ready = 1'b1;
    wait_edge(44); pll_locked = 1'b0;
    wait_edge(47);

    // Lock glitch, memory timeout, retry, then soft resets.
    pll_locked = 1'b1; mem_ready = 1'b0;
    do_reset(2);
    expect_at(25,  8'b0_0_0_0_0_000, "glitch_pre_mem");
    expect_at(26,  8'b1_0_0_0_0_001, "glitch_mem_rel");
    expect_at(89,  8'b1_0_0_0_0_001, "to_pre");
    expect_at(90,  8'b0_0_0_0_1_000, "to_fire");
    expect_at(106, 8'b1_0_0_0_1_001, "retry_mem_rel");
    expect_at(107, 8'b1_0_0_0_1_010, "retry_mem_ready");
    expect_at(115, 8'b1_1_0_0_1_011, "retry_video_rel");
    expect_at(123, 8'b1_1_1_1_1_100, "retry_run");
    expect_at(130, 8'b1_1_0_0_1_101, "soft_enter");
    expect_at(161, 8'b1_1_0_0_1_101, "soft_hold_last");
    expect_at(162, 8'b1_1_1_1_1_100, "soft_release");
    expect_at(170, 8'b1_1_0_0_1_101, "soft_long_enter");
    expect_at(202, 8'b1_1_0_0_1_101, "soft_long_held");
    expect_at(269, 8'b1_1_0_0_1_101, "soft_long_pre");
    expect_at(270, 8'b1_1_1_1_1_100, "soft_long_release");
    wait_edge(9);   pll_locked = 1'b0;
    wait_edge(10);  pll_locked = 1'b1;
    wait_edge(90);  mem_ready = 1'b1;
    wait_edge(129); soft_req = 1'b1;
    wait_edge(130); soft_req = 1'b0;
    wait_edge(169); soft_req = 1'b1;
    wait_edge(269); soft_req = 1'b0;
    wait_edge(272);

    // mem_ready on the timeout edge, soft_req ignored, reset during GAP_CPU.
    pll_locked = 1'b1; mem_ready = 1'b0;
    do_reset(3);
    expect_at(30, 8'b1_0_0_0_0_001, "soft_ignored");
    expect_at(79, 8'b1_0_0_0_0_001, "coinc_pre");
    expect_at(80, 8'b1_0_0_0_0_010, "coinc_mem_wins");
    expect_at(88, 8'b1_1_0_0_0_011, "coinc_video_rel");
    expect_at(93, 8'b0_0_0_0_0_000, "reset_in_gap_cpu");
    wait_edge(20); soft_req = 1'b1;
    wait_edge(30); soft_req = 1'b0;
    wait_edge(79); mem_ready = 1'b1;
    wait_edge(92); reset = 1'b1;
    wait_edge(94); reset = 1'b0;
    wait_edge(97);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
